mem_dump_streamer: RTL and testbench

- Post-run memory reader for the CPU integration.
- After the control unit halts, it reads a programmable window of the block memory through the memory's second port.
- It streams the words out, one word per transfer, over a valid/ready interface to the trace/UART sink.
- It is the read-back counterpart of the program-load path: that path fills memory before reset release, and this block empties it after execution.

---
 rtl/mem_dump_streamer.sv | 167 ++++++++++++++++
 tb/tb_mem_dump_streamer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer
//   Post-run memory reader. Once the CPU has halted, a Start pulse latches a
//   word window (BaseAddr, Count). The block reads that window through the
//   memory's second port and streams the words, in address order, to the
//   trace/UART sink.
//
// Ports
//   CLK, CtrlRstN        clock, asynchronous active-low reset
//   Start                one-cycle pulse, sampled only in IDLE
//   BaseAddr, Count      window start address and length (0 is legal), latched on Start
//   MemEn, MemAddr       port-B read request
//   MemDout              port-B read data, valid the cycle after MemEn
//   DumpData/Valid/Ready output stream (head of the output buffer)
//   DumpLast             marks the final word of the dump
//   Busy, Done           busy while streaming; one-cycle pulse after the last transfer
//   DbgState             current FSM state, for checkers
//
// Handshake: a word transfers on a rising CLK where DumpValid && DumpReady.
// Once DumpValid is high, DumpData/DumpLast hold until the word transfers.
// DumpValid never depends combinationally on DumpReady.
module mem_dump_streamer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2    // must be >= 2 to cover the read latency
) (
    input  logic              CLK,
    input  logic              CtrlRstN,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W-1:0] Count,
    output logic              MemEn,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemDout,
    output logic [DATA_W-1:0] DumpData,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic              DumpLast,
    output logic              Busy,
    output logic              Done,
    output logic [1:0]        DbgState
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0]  issue_left_q, issue_left_d;
    logic [ADDR_W-1:0]  deliver_left_q, deliver_left_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               inflight_q, inflight_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [PTR_W-1:0]   rd_idx_q, rd_idx_d;
    logic [PTR_W-1:0]   wr_idx_q, wr_idx_d;
    logic [DATA_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_d [FIFO_DEPTH];

    logic               pop;
    logic               mem_en;
    int                 used;

    function automatic logic [PTR_W-1:0] idx_inc(input logic [PTR_W-1:0] i);
        return (i == PTR_W'(FIFO_DEPTH - 1)) ? '0 : i + PTR_W'(1);
    endfunction

    // Read issue. An in-flight read already owns a buffer slot because it is
    // pushed on the next edge. A pop on this edge frees a slot in time for a
    // new issue, so a steady stream runs without bubbles.
    always_comb begin
        DumpValid = (occ_q != '0);
        pop       = DumpValid && DumpReady;
        used      = int'(occ_q) + int'(inflight_q) - int'(pop);
        mem_en    = (state_q == RUN) && (issue_left_q != '0) && (used < FIFO_DEPTH);
        MemEn     = mem_en;
        MemAddr   = mem_en ? ptr_q : mem_addr_q;
        DumpData  = fifo_q[rd_idx_q];
        DumpLast  = DumpValid && (deliver_left_q == ADDR_W'(1));
        Busy      = (state_q == RUN);
        Done      = (state_q == FIN);
        DbgState  = state_q;
    end

    // Control FSM and counters.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        issue_left_d   = issue_left_q;
        deliver_left_d = deliver_left_q;
        mem_addr_d     = mem_addr_q;
        inflight_d     = mem_en;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    ptr_d          = BaseAddr;
                    issue_left_d   = Count;
                    deliver_left_d = Count;
                    state_d        = (Count != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (mem_en) begin
                    ptr_d        = ptr_q + ADDR_W'(1);   // wraps at the top of memory
                    issue_left_d = issue_left_q - ADDR_W'(1);
                    mem_addr_d   = ptr_q;
                end
                if (pop) begin
                    deliver_left_d = deliver_left_q - ADDR_W'(1);
                    if (deliver_left_q == ADDR_W'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output buffer: the word read last cycle is pushed; the head pops on transfer.
    always_comb begin
        fifo_d   = fifo_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (inflight_q) begin
            fifo_d[wr_idx_q] = MemDout;
            wr_idx_d         = idx_inc(wr_idx_q);
        end
        if (pop) begin
            rd_idx_d = idx_inc(rd_idx_q);
        end
        occ_d = occ_q + OCC_W'(inflight_q) - OCC_W'(pop);
    end

    always_ff @(posedge CLK or negedge CtrlRstN) begin
        if (!CtrlRstN) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            mem_addr_q     <= '0;
            inflight_q     <= 1'b0;
            occ_q          <= '0;
            rd_idx_q       <= '0;
            wr_idx_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            issue_left_q   <= issue_left_d;
            deliver_left_q <= deliver_left_d;
            mem_addr_q     <= mem_addr_d;
            inflight_q     <= inflight_d;
            occ_q          <= occ_d;
            rd_idx_q       <= rd_idx_d;
            wr_idx_q       <= wr_idx_d;
            fifo_q         <= fifo_d;
        end
    end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Bench for mem_dump_streamer: a behavioural synchronous-read memory holding
// 0x1000+addr, a scenario task per feature and an expected-word queue.
module tb_mem_dump_streamer;

  logic        CLK = 1'b0;
  logic        CtrlRstN;
  logic        Start;
  logic [15:0] BaseAddr;
  logic [15:0] Count;
  logic        MemEn;
  logic [15:0] MemAddr;
  logic [15:0] MemDout;
  logic [15:0] DumpData;
  logic        DumpValid;
  logic        DumpReady;
  logic        DumpLast;
  logic        Busy;
  logic        Done;
  logic [1:0]  DbgState;

  mem_dump_streamer #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(2)) dut (
    .CLK(CLK), .CtrlRstN(CtrlRstN), .Start(Start), .BaseAddr(BaseAddr), .Count(Count),
    .MemEn(MemEn), .MemAddr(MemAddr), .MemDout(MemDout),
    .DumpData(DumpData), .DumpValid(DumpValid), .DumpReady(DumpReady), .DumpLast(DumpLast),
    .Busy(Busy), .Done(Done), .DbgState(DbgState)
  );

  // clock / memory model
  always #5 CLK = ~CLK;

  logic [15:0] mem [65536];
  always @(posedge CLK) begin
    if (MemEn) MemDout <= mem[MemAddr];
  end

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_w;

  logic        obs_v, obs_l, obs_me, obs_done, obs_busy;
  logic [15:0] obs_d, obs_ma;

  // driver tasks
  task automatic start_dump(input logic [15:0] base, input logic [15:0] cnt);
    @(negedge CLK);
    Start = 1'b1; BaseAddr = base; Count = cnt;
    for (int i = 0; i < int'(cnt); i++) exp_q.push_back(16'h1000 + base + 16'(i));
    @(posedge CLK);
    #1;
    Start = 1'b0; BaseAddr = 16'($urandom); Count = 16'($urandom);
  endtask

  // Drive ready/start for one cycle, sample outputs mid-cycle, advance past the edge.
  task automatic tick(input logic rdy, input logic st);
    @(negedge CLK);
    DumpReady = rdy; Start = st;
    #1;
    obs_v = DumpValid; obs_d = DumpData; obs_l = DumpLast; obs_me = MemEn;
    obs_ma = MemAddr; obs_done = Done; obs_busy = Busy;
    @(posedge CLK);
  endtask

  task automatic test_reset;
    CtrlRstN = 1'b0; Start = 1'b0; BaseAddr = '0; Count = '0; DumpReady = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    total_cnt++;
    if ({MemEn, MemAddr, DumpData, DumpValid, DumpLast, Busy, Done} !== 36'h0)
      $display("FAIL reset_outputs: got %h required 0", {MemEn, MemAddr, DumpData, DumpValid, DumpLast, Busy, Done});
    else pass_cnt++;
    @(negedge CLK); CtrlRstN = 1'b1;
    tick(1'b1, 1'b0);
    total_cnt++;
    if ({obs_v, obs_me, obs_busy, obs_done} !== 4'b0)
      $display("FAIL reset_idle: got %b required 0000", {obs_v, obs_me, obs_busy, obs_done});
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int first_v = -1, last_x = -1, done_c = -1, n_x = 0;
    start_dump(16'h0010, 16'd4);
    for (int c = 0; c < 30; c++) begin
      tick(1'b1, 1'b0);
      if (c == 0) begin
        total_cnt++;
        if ({obs_me, obs_ma} !== {1'b1, 16'h0010})
          $display("FAIL basic_first_read: got en=%b addr=%h required en=1 addr=0010", obs_me, obs_ma);
        else pass_cnt++;
      end
      if (obs_v && first_v < 0) first_v = c;
      if (obs_v) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        total_cnt++;
        if (obs_d !== exp_w) $display("FAIL basic_data: got %h required %h", obs_d, exp_w);
        else pass_cnt++;
        total_cnt++;
        if (obs_l !== (exp_q.size() == 0)) $display("FAIL basic_last: got %b required %b", obs_l, exp_q.size() == 0);
        else pass_cnt++;
        n_x++; last_x = c;
      end
      if (obs_done) begin
        done_c = c;
        total_cnt++;
        if (obs_busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b required 0", obs_busy);
        else pass_cnt++;
        break;
      end
    end
    total_cnt++;
    if (first_v != 2) $display("FAIL basic_latency: got %0d required 2", first_v); else pass_cnt++;
    total_cnt++;
    if ({n_x, last_x, done_c} != {32'd4, 32'd5, 32'd6})
      $display("FAIL basic_timing: got xfers=%0d last=%0d done=%0d required 4 5 6", n_x, last_x, done_c);
    else pass_cnt++;
    tick(1'b1, 1'b0);
    total_cnt++;
    if ({obs_done, obs_busy, obs_v} !== 3'b0) $display("FAIL basic_after_done: got %b required 000", {obs_done, obs_busy, obs_v});
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [5:0]  pat = 6'b101001;   // cycles 0..5: 1,0,0,1,0,1
    logic        rdy, prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [15:0] prev_d = '0;
    int n_x = 0, issued = 0, max_out = 0, done_n = 0;
    start_dump(16'h0010, 16'd4);
    for (int c = 0; c < 100 && done_n == 0; c++) begin
      rdy = (c < 6) ? pat[c] : 1'($urandom_range(0, 1));
      tick(rdy, 1'b0);
      if (prev_v && !prev_r) begin
        total_cnt++;
        if ({obs_v, obs_d, obs_l} !== {1'b1, prev_d, prev_l})
          $display("FAIL bp_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b", obs_v, obs_d, obs_l, prev_d, prev_l);
        else pass_cnt++;
      end
      if (obs_me) issued++;
      if (obs_v && rdy) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        total_cnt++;
        if (obs_d !== exp_w) $display("FAIL bp_data: got %h required %h", obs_d, exp_w);
        else pass_cnt++;
        total_cnt++;
        if (obs_l !== (exp_q.size() == 0)) $display("FAIL bp_last: got %b required %b", obs_l, exp_q.size() == 0);
        else pass_cnt++;
        n_x++;
      end
      if (issued - n_x > max_out) max_out = issued - n_x;
      if (obs_done) done_n++;
      prev_v = obs_v; prev_r = rdy; prev_d = obs_d; prev_l = obs_l;
    end
    total_cnt++;
    if ({n_x, issued, done_n} != {32'd4, 32'd4, 32'd1})
      $display("FAIL bp_counts: got xfers=%0d reads=%0d done=%0d required 4 4 1", n_x, issued, done_n);
    else pass_cnt++;
    total_cnt++;
    if (max_out != 2) $display("FAIL bp_outstanding: got %0d required 2", max_out); else pass_cnt++;
  endtask

  task automatic test_zero_count;
    int n_me = 0, n_v = 0, n_done = 0;
    start_dump(16'h0020, 16'd0);
    tick(1'b1, 1'b0);
    total_cnt++;
    if ({obs_done, obs_busy} !== 2'b10) $display("FAIL zero_done: got done=%b busy=%b required 1 0", obs_done, obs_busy);
    else pass_cnt++;
    if (obs_me) n_me++;
    if (obs_v) n_v++;
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b0);
      if (obs_me) n_me++;
      if (obs_v) n_v++;
      if (obs_done) n_done++;
    end
    total_cnt++;
    if ({n_me, n_v, n_done} != 96'd0)
      $display("FAIL zero_activity: got reads=%0d valids=%0d extra_done=%0d required 0 0 0", n_me, n_v, n_done);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [15:0] addrs [3];
    logic [15:0] want [3];
    int n_me = 0, done_n = 0;
    want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000;
    start_dump(16'hFFFE, 16'd3);
    for (int c = 0; c < 30 && done_n == 0; c++) begin
      tick(1'b1, 1'b0);
      if (obs_me) begin
        if (n_me < 3) addrs[n_me] = obs_ma;
        n_me++;
      end
      if (obs_v) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        total_cnt++;
        if (obs_d !== exp_w) $display("FAIL wrap_data: got %h required %h", obs_d, exp_w);
        else pass_cnt++;
      end
      if (obs_done) done_n++;
    end
    total_cnt++;
    if (n_me != 3) $display("FAIL wrap_reads: got %0d required 3", n_me); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (addrs[i] !== want[i]) $display("FAIL wrap_addr%0d: got %h required %h", i, addrs[i], want[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_n != 1 || exp_q.size() != 0) $display("FAIL wrap_end: got done=%0d left=%0d required 1 0", done_n, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n_x = 0, stall = 0, n_act = 0, done_n = 0;
    start_dump(16'h0040, 16'd8);
    for (int c = 0; c < 30 && stall < 3; c++) begin
      tick(n_x < 2, 1'b0);
      if (n_x >= 2) stall++;
      else if (obs_v) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        total_cnt++;
        if (obs_d !== exp_w) $display("FAIL rstmid_data: got %h required %h", obs_d, exp_w);
        else pass_cnt++;
        n_x++;
      end
    end
    @(negedge CLK);
    #2;
    CtrlRstN = 1'b0;
    #1;
    total_cnt++;
    if ({MemEn, MemAddr, DumpData, DumpValid, DumpLast, Busy, Done} !== 36'h0)
      $display("FAIL rstmid_outputs: got %h required 0", {MemEn, MemAddr, DumpData, DumpValid, DumpLast, Busy, Done});
    else pass_cnt++;
    exp_q.delete();
    @(negedge CLK); CtrlRstN = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, 1'b0);
      if (obs_v || obs_me || obs_busy || obs_done) n_act++;
    end
    total_cnt++;
    if (n_act != 0) $display("FAIL rstmid_quiet: got %0d active cycles required 0", n_act); else pass_cnt++;
    n_x = 0;
    start_dump(16'h0050, 16'd2);
    for (int c = 0; c < 30 && done_n == 0; c++) begin
      tick(1'b1, 1'b0);
      if (obs_v) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        total_cnt++;
        if (obs_d !== exp_w) $display("FAIL rstmid_redump: got %h required %h", obs_d, exp_w);
        else pass_cnt++;
        n_x++;
      end
      if (obs_done) done_n++;
    end
    total_cnt++;
    if (n_x != 2 || done_n != 1) $display("FAIL rstmid_redump_count: got xfers=%0d done=%0d required 2 1", n_x, done_n);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored;
    int n_x = 0, done_n = 0, n_act = 0;
    start_dump(16'h0010, 16'd4);
    BaseAddr = 16'h0080; Count = 16'd4;
    for (int c = 0; c < 16; c++) begin
      tick(1'b1, c == 1);
      if (obs_v) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        total_cnt++;
        if (obs_d !== exp_w) $display("FAIL ignore_data: got %h required %h", obs_d, exp_w);
        else pass_cnt++;
        n_x++;
      end
      if (obs_done) done_n++;
      if (done_n != 0 && !obs_done && (obs_v || obs_me || obs_busy)) n_act++;
    end
    total_cnt++;
    if ({n_x, done_n, n_act} != {32'd4, 32'd1, 32'd0})
      $display("FAIL ignore_counts: got xfers=%0d done=%0d late_activity=%0d required 4 1 0", n_x, done_n, n_act);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_reset_mid();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
